// File: rtl/voxel_ram_arbiter_if.sv
// Requester and RAM-side bus of voxel_ram_arbiter.
// Optional stats signals exist only when VOXEL_ARB_STATS_EN is defined.
interface voxel_ram_arbiter_if #(
  parameter int NUM_VTU = 4,
  parameter int POS_W   = 16,
  parameter int TYPE_W  = 8
);
  logic [NUM_VTU-1:0][POS_W-1:0] req_addr;
  logic [NUM_VTU-1:0]            req_read_enable;
  logic [NUM_VTU-1:0]            req_flush;
  logic [TYPE_W-1:0]             req_out;
  logic [NUM_VTU-1:0]            req_valid;
  logic [POS_W-1:0]              mem_addr;
  logic                          mem_read_enable;
  logic [TYPE_W-1:0]             mem_out;
`ifdef VOXEL_ARB_STATS_EN
  logic [31:0]                   stat_reads;
  logic [31:0]                   stat_stalls;
`endif

  modport slave (
    input  req_addr, req_read_enable, req_flush, mem_out,
    output req_out, req_valid, mem_addr, mem_read_enable
`ifdef VOXEL_ARB_STATS_EN
    , output stat_reads, stat_stalls
`endif
  );

  modport master (
    output req_addr, req_read_enable, req_flush, mem_out,
    input  req_out, req_valid, mem_addr, mem_read_enable
`ifdef VOXEL_ARB_STATS_EN
    , input stat_reads, stat_stalls
`endif
  );
endinterface

// File: rtl/voxel_ram_arbiter.sv
// Round-robin sharing of one voxel block RAM read port among NUM_VTU traversal units.
// Define VOXEL_ARB_STATS_EN to add the stat_reads / stat_stalls counters.
module voxel_ram_arbiter #(
  parameter int NUM_VTU     = 4,
  parameter int RAM_LATENCY = 2,
  parameter int POS_W       = 16,
  parameter int TYPE_W      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  voxel_ram_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_VTU > 1) ? $clog2(NUM_VTU) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_VTU - 1);
  localparam logic [PTR_W:0]   NUM_W     = (PTR_W+1)'(NUM_VTU);

  logic [NUM_VTU-1:0]            busy_q, busy_d;
  logic [NUM_VTU-1:0]            pend_q, pend_d;
  logic [NUM_VTU-1:0][POS_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]              rr_q, rr_d;
  logic                          mem_read_enable_q, mem_read_enable_d;
  logic [POS_W-1:0]              mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]              iss_port_q, iss_port_d;
  logic [RAM_LATENCY-1:0]        tag_vld_q, tag_vld_d;
  logic [RAM_LATENCY-1:0][PTR_W-1:0] tag_port_q, tag_port_d;
  logic [TYPE_W-1:0]             req_out_q, req_out_d;
  logic [NUM_VTU-1:0]            req_valid_q, req_valid_d;

  logic [NUM_VTU-1:0]            capture_s;
  logic [NUM_VTU-1:0]            cand_s;
  logic                          grant_vld_s;
  logic [PTR_W-1:0]              grant_idx_s;
  logic [NUM_VTU-1:0]            grant_oh_s;
  logic                          exit_vld_s;
  logic [PTR_W-1:0]              exit_port_s;

  // A request arriving at an idle port competes in the same cycle it is captured.
  always_comb begin
    capture_s = bus.req_read_enable & ~busy_q & ~bus.req_flush;
    cand_s    = (pend_q | capture_s) & ~bus.req_flush;
  end

  // Round-robin pick: lowest offset from rr_q wins.
  always_comb begin
    logic [PTR_W:0]   sum_s;
    logic [PTR_W:0]   wrap_s;
    logic [PTR_W-1:0] port_s;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    sum_s       = '0;
    wrap_s      = '0;
    port_s      = '0;
    for (int k = NUM_VTU - 1; k >= 0; k--) begin
      sum_s       = {1'b0, rr_q} + (PTR_W+1)'(k);
      wrap_s      = (sum_s >= NUM_W) ? (sum_s - NUM_W) : sum_s;
      port_s      = wrap_s[PTR_W-1:0];
      grant_idx_s = cand_s[port_s] ? port_s : grant_idx_s;
      grant_vld_s = grant_vld_s | cand_s[port_s];
    end
    grant_oh_s = grant_vld_s ? (NUM_VTU'(1) << grant_idx_s) : '0;
    rr_d       = grant_vld_s ? ((grant_idx_s == LAST_PORT) ? '0 : grant_idx_s + PTR_W'(1)) : rr_q;
  end

  always_comb begin
    exit_vld_s  = tag_vld_q[RAM_LATENCY-1] & ~bus.req_flush[tag_port_q[RAM_LATENCY-1]];
    exit_port_s = tag_port_q[RAM_LATENCY-1];
  end

  // Per-port busy/pending/address; flush outranks capture.
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    addr_d = addr_q;
    for (int i = 0; i < NUM_VTU; i++) begin
      if (bus.req_flush[i]) begin
        busy_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end else if (capture_s[i]) begin
        busy_d[i] = 1'b1;
        pend_d[i] = ~grant_oh_s[i];
        addr_d[i] = bus.req_addr[i];
      end else if (exit_vld_s && (exit_port_s == PTR_W'(i))) begin
        busy_d[i] = 1'b0;
        pend_d[i] = 1'b0;
      end else if (grant_oh_s[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Issue stage plus tag shift that tracks the RAM pipeline; flush kills matching tags.
  always_comb begin
    mem_read_enable_d = grant_vld_s;
    mem_addr_d        = grant_vld_s ? (busy_q[grant_idx_s] ? addr_q[grant_idx_s]
                                                           : bus.req_addr[grant_idx_s])
                                    : mem_addr_q;
    iss_port_d        = grant_vld_s ? grant_idx_s : iss_port_q;
    tag_vld_d         = '0;
    tag_port_d        = tag_port_q;
    tag_vld_d[0]      = mem_read_enable_q & ~bus.req_flush[iss_port_q];
    tag_port_d[0]     = iss_port_q;
    for (int k = 1; k < RAM_LATENCY; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1] & ~bus.req_flush[tag_port_q[k-1]];
      tag_port_d[k] = tag_port_q[k-1];
    end
    req_valid_d = exit_vld_s ? (NUM_VTU'(1) << exit_port_s) : '0;
    req_out_d   = exit_vld_s ? bus.mem_out : req_out_q;
  end

  // State registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q            <= '0;
      pend_q            <= '0;
      addr_q            <= '0;
      rr_q              <= '0;
      mem_read_enable_q <= 1'b0;
      mem_addr_q        <= '0;
      iss_port_q        <= '0;
      tag_vld_q         <= '0;
      tag_port_q        <= '0;
      req_out_q         <= '0;
      req_valid_q       <= '0;
    end else begin
      busy_q            <= busy_d;
      pend_q            <= pend_d;
      addr_q            <= addr_d;
      rr_q              <= rr_d;
      mem_read_enable_q <= mem_read_enable_d;
      mem_addr_q        <= mem_addr_d;
      iss_port_q        <= iss_port_d;
      tag_vld_q         <= tag_vld_d;
      tag_port_q        <= tag_port_d;
      req_out_q         <= req_out_d;
      req_valid_q       <= req_valid_d;
    end
  end

  assign bus.req_out         = req_out_q;
  assign bus.req_valid       = req_valid_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_read_enable = mem_read_enable_q;

`ifdef VOXEL_ARB_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;
  logic        stall_s;

  // Saturating activity counters.
  always_comb begin
    stall_s       = |(cand_s & ~grant_oh_s);
    stat_reads_d  = (mem_read_enable_q && (stat_reads_q != 32'hFFFF_FFFF))
                    ? stat_reads_q + 32'd1 : stat_reads_q;
    stat_stalls_d = (stall_s && (stat_stalls_q != 32'hFFFF_FFFF))
                    ? stat_stalls_q + 32'd1 : stat_stalls_q;
  end

  // Counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_reads_q  <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign bus.stat_reads  = stat_reads_q;
  assign bus.stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Randomized bench for voxel_ram_arbiter against a delivery-schedule reference model.
module tb_voxel_ram_arbiter;
  localparam int N      = 4;
  localparam int L      = 2;
  localparam int POS_W  = 16;
  localparam int TYPE_W = 8;

  logic clk_in = 1'b0;
  logic rst_in;

  voxel_ram_arbiter_if #(.NUM_VTU(N), .POS_W(POS_W), .TYPE_W(TYPE_W)) bus ();

  voxel_ram_arbiter #(
    .NUM_VTU(N), .RAM_LATENCY(L), .POS_W(POS_W), .TYPE_W(TYPE_W)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [TYPE_W-1:0] ram_fn(input logic [POS_W-1:0] a);
    return a[TYPE_W-1:0] ^ 8'h05;
  endfunction

  // Fixed-latency RAM behaviour.
  logic [TYPE_W-1:0] ram_pipe [L];
  always @(posedge clk_in) begin
    ram_pipe[0] <= bus.mem_read_enable ? ram_fn(bus.mem_addr) : 8'h00;
    for (int k = 1; k < L; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign bus.mem_out = ram_pipe[L-1];

  // Reference model: each grant schedules a future delivery (cycle, port, data).
  typedef struct {
    int               due;
    int               port;
    logic [TYPE_W-1:0] data;
  } deliv_t;

  deliv_t            evq[$];
  bit                m_busy [N];
  bit                m_pend [N];
  logic [POS_W-1:0]  m_addr [N];
  int                m_rr;
  bit                exp_ren;
  logic [POS_W-1:0]  exp_maddr;
  logic [TYPE_W-1:0] exp_out;
  int                exp_reads;
  int                exp_stalls;
  int                cyc;
  int                n_checks;
  int                n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_valid;
    exp_valid = '0;
    for (int j = evq.size() - 1; j >= 0; j--) begin
      if (evq[j].due == cyc) begin
        exp_valid[evq[j].port] = 1'b1;
        exp_out = evq[j].data;
        evq.delete(j);
      end
    end
    check_eq("req_valid", 32'(bus.req_valid), 32'(exp_valid));
    check_eq("valid_onehot", 32'($onehot0(bus.req_valid)), 32'd1);
    check_eq("req_out", 32'(bus.req_out), 32'(exp_out));
    check_eq("mem_read_enable", 32'(bus.mem_read_enable), 32'(exp_ren));
    check_eq("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
`ifdef VOXEL_ARB_STATS_EN
    check_eq("stat_reads", bus.stat_reads, 32'(exp_reads));
    check_eq("stat_stalls", bus.stat_stalls, 32'(exp_stalls));
`endif
  endtask

  task automatic model_edge(input logic [N-1:0] ren, input logic [N-1:0] fl, input logic rst,
                            input logic [N-1:0][POS_W-1:0] ra);
    bit cand [N];
    bit old_busy [N];
    int g;
    int p;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_pend[i] = 1'b0;
      end
      evq.delete();
      m_rr       = 0;
      exp_ren    = 1'b0;
      exp_maddr  = '0;
      exp_out    = '0;
      exp_reads  = 0;
      exp_stalls = 0;
      return;
    end
    if (exp_ren) exp_reads++;
    for (int j = evq.size() - 1; j >= 0; j--)
      if (fl[evq[j].port]) evq.delete(j);
    old_busy = m_busy;
    for (int i = 0; i < N; i++)
      cand[i] = !fl[i] && (m_pend[i] || (ren[i] && !m_busy[i]));
    g = -1;
    for (int k = 0; k < N; k++) begin
      p = (m_rr + k) % N;
      if (g < 0 && cand[p]) g = p;
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i] && i != g) begin
        exp_stalls++;
        break;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (fl[i]) begin
        m_busy[i] = 1'b0;
        m_pend[i] = 1'b0;
      end else if (ren[i] && !old_busy[i]) begin
        m_busy[i] = 1'b1;
        m_addr[i] = ra[i];
        m_pend[i] = (i != g);
      end
    end
    foreach (evq[j])
      if (evq[j].due == cyc + 1) m_busy[evq[j].port] = 1'b0;
    if (g >= 0) begin
      exp_ren   = 1'b1;
      exp_maddr = m_addr[g];
      m_pend[g] = 1'b0;
      evq.push_back('{due: cyc + L + 2, port: g, data: ram_fn(m_addr[g])});
      m_rr = (g + 1) % N;
    end else begin
      exp_ren = 1'b0;
    end
  endtask

  task automatic run_cycle(input logic [N-1:0] ren, input logic [N-1:0] fl, input logic rst);
    logic [N-1:0][POS_W-1:0] ra;
    check_outputs();
    for (int i = 0; i < N; i++) ra[i] = POS_W'($urandom);
    bus.req_addr        = ra;
    bus.req_read_enable = ren;
    bus.req_flush       = fl;
    rst_in              = rst;
    model_edge(ren, fl, rst, ra);
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle('0, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] ren;
    logic [N-1:0] fl;
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    m_rr       = 0;
    exp_ren    = 1'b0;
    exp_maddr  = '0;
    exp_out    = '0;
    exp_reads  = 0;
    exp_stalls = 0;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_pend[i] = 1'b0;
      m_addr[i] = '0;
    end
    rst_in              = 1'b1;
    bus.req_addr        = '0;
    bus.req_read_enable = '0;
    bus.req_flush       = '0;
    @(posedge clk_in);
    #1;
    run_cycle('0, '0, 1'b1);
    run_cycle('0, '0, 1'b1);

    // single port 0 read
    run_cycle(4'b0001, '0, 1'b0);
    idle(6);

    // all ports in the same cycle
    run_cycle(4'b1111, '0, 1'b0);
    idle(8);

    // port 2 held, ports 0 and 3 once
    run_cycle(4'b1101, '0, 1'b0);
    for (int i = 0; i < 9; i++) run_cycle(4'b0100, '0, 1'b0);
    idle(6);

    // flush port 1 one cycle after its grant, then re-request
    run_cycle(4'b0011, '0, 1'b0);
    run_cycle('0, '0, 1'b0);
    run_cycle('0, 4'b0010, 1'b0);
    run_cycle(4'b0010, '0, 1'b0);
    idle(6);

    // reset with reads in flight
    run_cycle(4'b1111, '0, 1'b0);
    run_cycle('0, '0, 1'b0);
    run_cycle('0, '0, 1'b0);
    run_cycle('0, '0, 1'b1);
    idle(8);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      ren = N'($urandom);
      fl  = '0;
      for (int i = 0; i < N; i++) fl[i] = ($urandom_range(15) == 0);
      run_cycle(ren, fl, ($urandom_range(299) == 0));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/voxel_ram_arbiter.md
# voxel_ram_arbiter

Shares one voxel-world block RAM read port among `NUM_VTU` voxel traversal units inside the orchestrator. Each VTU issues single outstanding reads; the arbiter captures them, grants one per cycle round-robin, tracks which port each in-flight read belongs to through the fixed RAM latency, and returns the block type with a one-cycle valid pulse to the owner. Per-port flush lets the orchestrator restart a single VTU on a new ray without corrupting other ports.

## Interface
Parameters:
- `NUM_VTU`, 4: number of requester ports (≥1).
- `RAM_LATENCY`, 2: cycles from `mem_read_enable` high to `mem_out` valid (≥1).

Ports:
- `clk_in`  in  1  clock; all logic on rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `req_addr[NUM_VTU]`  in  BlockPos  per-port read address.
- `req_read_enable[NUM_VTU]`  in  1  per-port read request.
- `req_flush[NUM_VTU]`  in  1  cancel port's pending/in-flight read.
- `req_out`  out  BlockType  returned block, shared by all ports.
- `req_valid[NUM_VTU]`  out  1  one-cycle pulse: `req_out` belongs to this port.
- `mem_addr`  out  BlockPos  RAM address (registered).
- `mem_read_enable`  out  1  RAM read strobe (registered).
- `mem_out`  in  BlockType  RAM read data.

## Operation
- Per-port state: `busy` flag, captured address register. Port idle when `busy`=0.
- Capture: on edge where `req_read_enable[i]`=1 and `busy[i]`=0 and `req_flush[i]`=0, latch `req_addr[i]`, set `busy[i]`, mark pending. `req_read_enable` while busy ignored (level or pulse both legal).
- Arbitration: each cycle, among pending-not-issued ports, grant first at or after round-robin pointer `rr` (wraps at `NUM_VTU`). Grant drives `mem_addr`/`mem_read_enable`=1 next cycle; pointer becomes grant+1 mod `NUM_VTU`. No pending → `mem_read_enable`=0, pointer unchanged.
- Tag pipeline: `RAM_LATENCY`-deep shift of {valid, port index} parallel to the RAM. On tag exit with valid=1: register `mem_out` into `req_out`, pulse `req_valid[port]`, clear `busy[port]`.
- Port may re-request on the same edge its `req_valid` is high (captured, since `busy` clears that edge).
- Flush on port i: clears `busy[i]`/pending, invalidates any tag for i in flight (its data dropped, no `req_valid[i]`). Flush has priority over simultaneous capture. Other ports unaffected.
- `rst_in`: clears all busy/pending, all tags, `rr`=0; in-flight RAM data discarded.

## Timing
- Reset values: `req_valid`=0, `req_out`=0, `mem_read_enable`=0, `mem_addr`=0.
- Uncontended latency: request sampled at edge T → `mem_read_enable` high cycle T+1 → `req_valid` high cycle T+1+`RAM_LATENCY`+1 (= `RAM_LATENCY`+2 after request; 4 at default).
- Throughput: one RAM read per cycle when ≥1 pending; back-to-back grants to different ports.
- Worst-case grant wait with all ports pending: `NUM_VTU`-1 cycles.
- `req_valid` one-hot or zero every cycle; `req_out` holds last value when no valid.
- `NUM_VTU`=1: pointer constant 0, no arbitration cycles added.

## Configuration
- `VOXEL_ARB_STATS_EN` defined: adds outputs `stat_reads` (32-bit, increments per `mem_read_enable` cycle) and `stat_stalls` (32-bit, increments each cycle ≥1 port pending but not granted); both clear on `rst_in`, saturate at all-ones.
- Undefined: ports and counters absent; no other behaviour change.

## Test plan
- Single port 0 reads addr A at cycle 0 with RAM model returning A^0x5 → `mem_read_enable` cycle 1, `req_valid[0]` cycle 4, `req_out`=A^0x5.
- All 4 ports request same edge after reset → grants in order 0,1,2,3 on consecutive cycles; valids cycles 4,5,6,7, each with its own data.
- Port 2 held continuously requesting, ports 0/3 requesting once → grants 0,2,3,2; no port starved; `req_valid` never multi-hot.
- Port 1 flushed 1 cycle after grant while port 0 read in flight → no `req_valid[1]`, port 0 data delivered; port 1 re-request next cycle served normally.
- `rst_in` asserted with 3 reads in flight → all outputs 0 next cycle, no `req_valid` pulses afterwards from stale tags.
- With `VOXEL_ARB_STATS_EN`, 4-port simultaneous burst → `stat_reads`=4, `stat_stalls`=3.
